ps2_keyboard: RTL and testbench
===============================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 25000, meaning clk cycles without a PS/2 clock falling edge before a partial frame is discarded.
REQ-002 SHALL have port clk  input  1  system clock; the single clock domain.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-006 SHALL have port keycode  output  16  Hack code of the key currently held, 0 when none; feeds the memory map KBD register.
REQ-007 SHALL have port byte_valid  output  1  one-cycle pulse when a frame is accepted.
REQ-008 SHALL have port frame_error  output  1  one-cycle pulse when a frame is rejected.

Function
REQ-009 SHALL pass ps2_clk and ps2_data each through a 2-flop synchroniser before any use.
REQ-010 SHALL detect a falling edge as synchronised ps2_clk high on the previous cycle and low on the current cycle; each edge samples synchronised ps2_data once.
REQ-011 SHALL use FSM states IDLE, SHIFT and CHECK: IDLE->SHIFT on an edge sampling 0 (start bit); edges sampling 1 in IDLE are ignored.
REQ-012 SHALL in SHIFT collect 8 data bits LSB first, then the parity bit, then the stop bit, with a 4-bit bit counter; the stop-bit edge moves to CHECK.
REQ-013 SHALL in CHECK (one cycle) accept the frame only if stop=1 and, when parity checking is compiled in, the ones count over data+parity is odd; accept pulses byte_valid, reject pulses frame_error; return to IDLE either way.
REQ-014 SHALL latch the data byte for processing in the cycle after the stop-bit edge; keycode SHALL reflect that byte 2 cycles after the stop-bit edge.
REQ-015 SHALL count clk cycles since the last edge while in SHIFT; at TIMEOUT_CYCLES it SHALL return to IDLE, clear the bit counter, pulse frame_error and leave keycode unchanged.
REQ-016 SHALL on accepted byte 0xF0 set a break flag; on 0xE0 set an extended flag; both flags persist until the next non-prefix byte.
REQ-017 SHALL translate a non-prefix byte using the extended flag: set-2 A..Z -> 65..90 (uppercase, no shift tracking); 0x45,16,1E,26,25,2E,36,3D,3E,46 -> 48..57; 0x29 -> 32; 0x5A -> 128; 0x66 -> 129; 0x76 -> 140; E0 6B/75/74/72 -> 130/131/132/133; any other byte -> 0 (unmapped).
REQ-018 SHALL on a make code (break flag clear) with a nonzero translation load keycode with that value; the most recent make wins.
REQ-019 SHALL on a break code clear keycode to 0 only if its translation equals the current keycode; otherwise keycode is unchanged.
REQ-020 SHALL clear both flags after any non-prefix byte, mapped or not.
REQ-021 SHALL leave keycode and flags untouched by rejected or timed-out frames.
REQ-022 SHALL ignore typematic repeat makes of the held key (keycode is rewritten with the same value).

Reset
REQ-023 SHALL on reset set FSM to IDLE, bit counter, timeout counter, break and extended flags, keycode, byte_valid and frame_error to 0, and synchroniser flops to 1 (idle bus).
REQ-024 SHALL on reset mid-frame discard the partial frame; the next start bit after reset deassertion begins a fresh frame.

Configuration
REQ-025 SHALL check odd parity in CHECK when PS2_PARITY_CHECK_EN is defined.
REQ-026 SHALL without PS2_PARITY_CHECK_EN still shift in the parity bit but ignore its value, and accept a frame on stop=1 alone.

Verification
REQ-027 SHALL cover: frame 0x1C with parity 0 and stop 1 -> byte_valid pulse; keycode=65 2 cycles after the stop edge.
REQ-028 SHALL cover: with keycode=65, send F0 then 1C -> keycode=0; send F0 then 1B ('S') instead -> keycode stays 65.
REQ-029 SHALL cover: E0 75 -> keycode=131; then E0 F0 75 -> keycode=0; then 0x75 alone -> keycode=0 (unmapped without E0).
REQ-030 SHALL cover: frame 0x1C with parity 1 -> with PS2_PARITY_CHECK_EN, frame_error pulse and keycode unchanged; without it, keycode=65.
REQ-031 SHALL cover: start bit plus 4 data bits then silence for TIMEOUT_CYCLES -> frame_error pulse, FSM IDLE; next full frame 0x29 -> keycode=32.
REQ-032 SHALL cover: reset asserted after the 5th bit of a frame -> all outputs 0; next frame 0x5A -> keycode=128.

Source files
------------

// File: rtl/ps2_keyboard.sv
// PS/2 set-2 keyboard receiver feeding the Hack KBD register.
// Synchronises the raw PS/2 lines, deframes 11-bit frames, tracks the
// F0 (break) and E0 (extended) prefixes and presents the Hack code of the
// most recently pressed key that is still held.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames whose
// data+parity ones count is even.
module ps2_keyboard #(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        byte_valid,
  output logic        frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          state;
  logic            clk_sync1;
  logic            clk_sync2;
  logic            clk_prev;
  logic            data_sync1;
  logic            data_sync2;
  logic [3:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity_bit;
  logic            stop_bit;
  logic [TW-1:0]   timer;
  logic [7:0]      rx_byte;
  logic            brk;
  logic            ext;
  logic            fall;
  logic [15:0]     code;

  // Frame acceptance rule: stop bit must be 1; parity only when compiled in.
  function automatic logic frame_ok(input logic stop, input logic [7:0] data,
                                    input logic parity);
`ifdef PS2_PARITY_CHECK_EN
    return stop & (^{data, parity});
`else
    return stop & (parity | ~parity) & (data == data);
`endif
  endfunction

  // Set-2 scan code to Hack code; 0 means the key is not mapped.
  function automatic logic [15:0] translate(input logic [7:0] sc, input logic extended);
    logic [15:0] r;
    r = 16'd0;
    if (extended) begin
      case (sc)
        8'h6B:   r = 16'd130;
        8'h75:   r = 16'd131;
        8'h74:   r = 16'd132;
        8'h72:   r = 16'd133;
        default: r = 16'd0;
      endcase
    end else begin
      case (sc)
        8'h1C: r = 16'd65;  8'h32: r = 16'd66;  8'h21: r = 16'd67;
        8'h23: r = 16'd68;  8'h24: r = 16'd69;  8'h2B: r = 16'd70;
        8'h34: r = 16'd71;  8'h33: r = 16'd72;  8'h43: r = 16'd73;
        8'h3B: r = 16'd74;  8'h42: r = 16'd75;  8'h4B: r = 16'd76;
        8'h3A: r = 16'd77;  8'h31: r = 16'd78;  8'h44: r = 16'd79;
        8'h4D: r = 16'd80;  8'h15: r = 16'd81;  8'h2D: r = 16'd82;
        8'h1B: r = 16'd83;  8'h2C: r = 16'd84;  8'h3C: r = 16'd85;
        8'h2A: r = 16'd86;  8'h1D: r = 16'd87;  8'h22: r = 16'd88;
        8'h35: r = 16'd89;  8'h1A: r = 16'd90;
        8'h45: r = 16'd48;  8'h16: r = 16'd49;  8'h1E: r = 16'd50;
        8'h26: r = 16'd51;  8'h25: r = 16'd52;  8'h2E: r = 16'd53;
        8'h36: r = 16'd54;  8'h3D: r = 16'd55;  8'h3E: r = 16'd56;
        8'h46: r = 16'd57;
        8'h29: r = 16'd32;  8'h5A: r = 16'd128; 8'h66: r = 16'd129;
        8'h76: r = 16'd140;
        default: r = 16'd0;
      endcase
    end
    return r;
  endfunction

  // Falling edge of the synchronised PS/2 clock.
  assign fall = clk_prev & ~clk_sync2;

  // Translation of the latched byte under the current extended flag.
  assign code = translate(rx_byte, ext);

  // Two-flop synchronisers plus edge-detect history; idle bus level is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync1  <= 1'b1;
      clk_sync2  <= 1'b1;
      clk_prev   <= 1'b1;
      data_sync1 <= 1'b1;
      data_sync2 <= 1'b1;
    end else begin
      clk_sync1  <= ps2_clk;
      clk_sync2  <= clk_sync1;
      clk_prev   <= clk_sync2;
      data_sync1 <= ps2_data;
      data_sync2 <= data_sync1;
    end
  end

  // Frame receiver FSM: start detect, bit shifting, timeout and frame check.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shift       <= 8'd0;
      parity_bit  <= 1'b0;
      stop_bit    <= 1'b0;
      timer       <= '0;
      rx_byte     <= 8'd0;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          timer   <= '0;
          bit_cnt <= 4'd0;
          if (fall && !data_sync2) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            timer   <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              shift <= {data_sync2, shift[7:1]};
            end else if (bit_cnt == 4'd8) begin
              parity_bit <= data_sync2;
            end else begin
              stop_bit <= data_sync2;
              state    <= CHECK;
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            timer       <= '0;
            frame_error <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        CHECK: begin
          if (frame_ok(stop_bit, shift, parity_bit)) begin
            byte_valid <= 1'b1;
            rx_byte    <= shift;
          end else begin
            frame_error <= 1'b1;
          end
          bit_cnt <= 4'd0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Prefix tracking and held-key register driven by each accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      keycode <= 16'd0;
      brk     <= 1'b0;
      ext     <= 1'b0;
    end else if (byte_valid) begin
      if (rx_byte == 8'hF0) begin
        brk <= 1'b1;
      end else if (rx_byte == 8'hE0) begin
        ext <= 1'b1;
      end else begin
        if (brk) begin
          if (code == keycode) begin
            keycode <= 16'd0;
          end
        end else if (code != 16'd0) begin
          keycode <= code;
        end
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus random frames
// compared every cycle against a scan-code-level model of the keyboard.
module tb_ps2_keyboard;

  localparam int T = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] keycode;
  logic        byte_valid;
  logic        frame_error;

  ps2_keyboard #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .byte_valid(byte_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: keyboard view (updated when a frame ends) and display view.
  logic [15:0] kc_model = 16'd0;
  logic [15:0] kc_cur = 16'd0;
  logic [15:0] kc_next = 16'd0;
  bit          brk_m = 1'b0;
  bit          ext_m = 1'b0;
  int          kc_at = -1;
  int          bv_at = -1;
  int          fe_at = -1;
  bit          chk_en = 1'b0;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                               8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                               8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                               8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                              8'h3D, 8'h3E, 8'h46};
  logic [7:0] arrows [4] = '{8'h6B, 8'h75, 8'h74, 8'h72};
  logic [7:0] specials [4] = '{8'h29, 8'h5A, 8'h66, 8'h76};
  logic [15:0] special_vals [4] = '{16'd32, 16'd128, 16'd129, 16'd140};

  function automatic logic [15:0] xlate(logic [7:0] b, bit e);
    if (e) begin
      for (int i = 0; i < 4; i++) if (arrows[i] == b) return 16'(130 + i);
      return 16'd0;
    end
    for (int i = 0; i < 26; i++) if (letters[i] == b) return 16'(65 + i);
    for (int i = 0; i < 10; i++) if (digits[i] == b) return 16'(48 + i);
    for (int i = 0; i < 4; i++) if (specials[i] == b) return special_vals[i];
    return 16'd0;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    if (kc_at >= 0 && cyc >= kc_at) begin
      kc_cur = kc_next;
      kc_at  = -1;
    end
    if (chk_en) begin
      check("keycode", keycode, kc_cur);
      check("byte_valid", 16'(byte_valid), (cyc == bv_at) ? 16'd1 : 16'd0);
      check("frame_error", 16'(frame_error), (cyc == fe_at) ? 16'd1 : 16'd0);
    end
  end

  task automatic wait_neg(int n);
    repeat (n) @(negedge clk);
  endtask

  // Model reaction to the stop-bit falling edge driven in cycle nf.
  task automatic model_frame(logic [7:0] b, bit par_good, bit stop, int nf);
    bit accept;
    logic [15:0] c;
`ifdef PS2_PARITY_CHECK_EN
    accept = stop && par_good;
`else
    accept = stop;
`endif
    if (accept) begin
      bv_at = nf + 4;
      if (b == 8'hF0) brk_m = 1'b1;
      else if (b == 8'hE0) ext_m = 1'b1;
      else begin
        c = xlate(b, ext_m);
        if (brk_m) begin
          if (c == kc_model) kc_model = 16'd0;
        end else if (c != 16'd0) kc_model = c;
        brk_m = 1'b0;
        ext_m = 1'b0;
      end
      kc_next = kc_model;
      kc_at   = nf + 5;
    end else begin
      fe_at = nf + 4;
    end
  endtask

  task automatic ps2_bit(bit b, output int nf);
    ps2_data = b;
    wait_neg(3);
    ps2_clk = 1'b0;
    nf = cyc;
    wait_neg(4);
    ps2_clk = 1'b1;
    wait_neg(3);
  endtask

  task automatic send_frame(logic [7:0] b, bit par_good = 1'b1, bit stop = 1'b1);
    int nf;
    bit par;
    par = par_good ? ~^b : ^b;
    ps2_bit(1'b0, nf);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], nf);
    ps2_bit(par, nf);
    ps2_data = stop;
    wait_neg(3);
    ps2_clk = 1'b0;
    nf = cyc;
    model_frame(b, par_good, stop, nf);
    wait_neg(4);
    ps2_clk = 1'b1;
    wait_neg(3);
    ps2_data = 1'b1;
    wait_neg(6);
  endtask

  // Start bit plus four data bits, then the bus goes quiet.
  task automatic send_partial(logic [3:0] bits, output int nf);
    ps2_bit(1'b0, nf);
    for (int i = 0; i < 4; i++) ps2_bit(bits[i], nf);
    ps2_data = 1'b1;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    kc_model = 16'd0; kc_cur = 16'd0; kc_next = 16'd0;
    brk_m = 1'b0; ext_m = 1'b0;
    kc_at = -1; bv_at = -1; fe_at = -1;
    wait_neg(n);
  endtask

  initial begin
    int nf;
    int r;
    logic [7:0] b;
    do_reset(3);
    chk_en = 1'b1;
    check("reset keycode", keycode, 16'd0);
    check("reset byte_valid", 16'(byte_valid), 16'd0);
    check("reset frame_error", 16'(frame_error), 16'd0);
    reset = 1'b0;
    wait_neg(4);

    // 'A' make, then release.
    send_frame(8'h1C);
    check("A make", keycode, 16'd65);
    send_frame(8'hF0); send_frame(8'h1C);
    check("A break", keycode, 16'd0);
    send_frame(8'h1C);
    send_frame(8'hF0); send_frame(8'h1B);
    check("S break keeps A", keycode, 16'd65);
    send_frame(8'h1C);
    check("A typematic", keycode, 16'd65);

    // Extended arrow up.
    send_frame(8'hE0); send_frame(8'h75);
    check("E0 75 up", keycode, 16'd131);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    check("E0 F0 75 release", keycode, 16'd0);
    send_frame(8'h75);
    check("75 unmapped", keycode, 16'd0);

    // Bad parity frame.
    send_frame(8'h29);
    send_frame(8'h1C, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("bad parity", keycode, 16'd32);
`else
    check("bad parity", keycode, 16'd65);
`endif

    // Bad stop bit is always rejected.
    send_frame(8'h5A, 1'b1, 1'b0);
    check("bad stop", keycode, kc_model);

    // Timeout of a partial frame.
    send_frame(8'hF0); send_frame(kc_model == 16'd65 ? 8'h1C : 8'h29);
    send_partial(4'b1010, nf);
    fe_at = nf + 3 + T;
    wait_neg(T + 20);
    send_frame(8'h29);
    check("after timeout", keycode, 16'd32);

    // Reset in the middle of a frame.
    send_frame(8'h1C);
    send_partial(4'b0110, nf);
    do_reset(3);
    check("midframe reset keycode", keycode, 16'd0);
    check("midframe reset byte_valid", 16'(byte_valid), 16'd0);
    check("midframe reset frame_error", 16'(frame_error), 16'd0);
    reset = 1'b0;
    wait_neg(4);
    send_frame(8'h5A);
    check("after reset enter", keycode, 16'd128);

    // Random traffic.
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: b = letters[$urandom_range(0, 25)];
        4: b = digits[$urandom_range(0, 9)];
        5: b = 8'hF0;
        6: b = 8'hE0;
        7: b = arrows[$urandom_range(0, 3)];
        8: b = specials[$urandom_range(0, 3)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame(b, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) != 0));
    end
    check("random final", keycode, kc_model);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
